// File: rtl/fir_decim_buffer.sv
// Decimating output buffer for the 4-tap FIR: keeps every DEC-th accepted sample
// in a small FIFO and hands it downstream over valid/ready, with a sticky overflow flag.
module fir_decim_buffer #(
  parameter int D_W   = 8,
  parameter int DEC   = 4,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [D_W-1:0] in_data,
  output logic           out_valid,
  output logic [D_W-1:0] out_data,
  input  logic           out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic           overflow,
  input  logic           clr_ovf
);

  localparam int CW = $clog2(DEC);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] PHASE_LAST = CW'(DEC - 1);
  localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);

  logic [CW-1:0]  phase;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    level_q;
  logic           ovf_q;
  logic [D_W-1:0] mem [DEPTH];

  logic keep;
  logic pop;
  logic full;
  logic push;
  logic drop;

  // A slot freed by a same-cycle pop can be reused, so a full FIFO still
  // accepts the kept sample when the consumer is draining.
  assign keep = in_valid && (phase == '0);
  assign pop  = (level_q != '0) && out_ready;
  assign full = (level_q == LEVEL_FULL);
  assign push = keep && (!full || pop);
  assign drop = keep && !push;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (in_valid) begin
      phase <= (phase == PHASE_LAST) ? '0 : phase + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + (AW + 1)'(1);
        2'b01:   level_q <= level_q - (AW + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // A drop on the same edge wins over a clear so no lost sample goes unreported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; its contents are
  // never observable while empty because out_data is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign level     = level_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Directed self-checking bench for fir_decim_buffer (D_W=8, DEC=4, DEPTH=4).
module tb_fir_decim_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] level;
  logic       overflow;
  logic       clr_ovf;

  int n_checks = 0;
  int n_errors = 0;

  fir_decim_buffer #(.D_W(8), .DEC(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    rst_n     = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    rst_n     = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++;
    if (out_data !== 8'h00) begin n_errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
    n_checks++;
    if (level !== 3'd0) begin n_errors++; $display("FAIL reset_level got %0d want 0", level); end
    n_checks++;
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic       exp_v;
    logic [7:0] exp_d;
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_data = 8'(i);
      step();
      exp_v = ((i - 1) % 4 == 0);
      exp_d = exp_v ? 8'(i) : 8'h00;
      n_checks++;
      if (out_valid !== exp_v) begin n_errors++; $display("FAIL basic_valid[%0d] got %b want %b", i, out_valid, exp_v); end
      n_checks++;
      if (out_data !== exp_d) begin n_errors++; $display("FAIL basic_data[%0d] got %h want %h", i, out_data, exp_d); end
      n_checks++;
      if (level !== {2'b00, exp_v}) begin n_errors++; $display("FAIL basic_level[%0d] got %0d want %0d", i, level, exp_v); end
      n_checks++;
      if (overflow !== 1'b0) begin n_errors++; $display("FAIL basic_overflow[%0d] got %b want 0", i, overflow); end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_gapped();
    logic       v_pat [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] d_pat [9] = '{8'd10, 8'hAA, 8'hAA, 8'd11, 8'd12, 8'hAA, 8'd13, 8'd14, 8'd15};
    logic       e_pat [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] exp_d;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = v_pat[i];
      in_data  = d_pat[i];
      step();
      exp_d = e_pat[i] ? d_pat[i] : 8'h00;
      n_checks++;
      if (out_valid !== e_pat[i]) begin n_errors++; $display("FAIL gapped_valid[%0d] got %b want %b", i, out_valid, e_pat[i]); end
      n_checks++;
      if (out_data !== exp_d) begin n_errors++; $display("FAIL gapped_data[%0d] got %h want %h", i, out_data, exp_d); end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_overflow();
    logic [2:0] exp_l;
    logic [7:0] exp_d;
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'(i);
      step();
      exp_l = (i / 4 + 1 > 4) ? 3'd4 : 3'(i / 4 + 1);
      n_checks++;
      if (level !== exp_l) begin n_errors++; $display("FAIL ovf_fill_level[%0d] got %0d want %0d", i, level, exp_l); end
      n_checks++;
      if (overflow !== (i >= 16)) begin n_errors++; $display("FAIL ovf_fill_flag[%0d] got %b want %b", i, overflow, (i >= 16)); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_d = 8'(4 * k);
      n_checks++;
      if (out_data !== exp_d) begin n_errors++; $display("FAIL ovf_drain_data[%0d] got %h want %h", k, out_data, exp_d); end
      step();
      n_checks++;
      if (level !== 3'(3 - k)) begin n_errors++; $display("FAIL ovf_drain_level[%0d] got %0d want %0d", k, level, 3 - k); end
    end
    n_checks++;
    if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL ovf_empty_valid got %b want 0", out_valid); end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_q [4] = '{8'd4, 8'd8, 8'd12, 8'h7F};
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 8'(i);
      step();
    end
    n_checks++;
    if (level !== 3'd4) begin n_errors++; $display("FAIL fullpop_pre_level got %0d want 4", level); end
    in_data   = 8'h7F;
    out_ready = 1'b1;
    step();
    n_checks++;
    if (level !== 3'd4) begin n_errors++; $display("FAIL fullpop_level got %0d want 4", level); end
    n_checks++;
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL fullpop_overflow got %b want 0", overflow); end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (out_data !== exp_q[k]) begin n_errors++; $display("FAIL fullpop_drain[%0d] got %h want %h", k, out_data, exp_q[k]); end
      step();
    end
    n_checks++;
    if (level !== 3'd0) begin n_errors++; $display("FAIL fullpop_end_level got %0d want 0", level); end
  endtask

  task automatic test_ovf_clear();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      in_data = 8'(i);
      step();
    end
    n_checks++;
    if (overflow !== 1'b1) begin n_errors++; $display("FAIL clr_set got %b want 1", overflow); end
    in_valid = 1'b0;
    clr_ovf  = 1'b1;
    step();
    n_checks++;
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL clr_plain got %b want 0", overflow); end
    clr_ovf  = 1'b0;
    in_valid = 1'b1;
    for (int i = 17; i <= 19; i++) begin
      in_data = 8'(i);
      step();
      n_checks++;
      if (overflow !== 1'b0) begin n_errors++; $display("FAIL clr_nonkept[%0d] got %b want 0", i, overflow); end
    end
    in_data = 8'd20;
    clr_ovf = 1'b1;
    step();
    n_checks++;
    if (overflow !== 1'b1) begin n_errors++; $display("FAIL clr_priority got %b want 1", overflow); end
    n_checks++;
    if (level !== 3'd4 || out_data !== 8'd0) begin
      n_errors++; $display("FAIL clr_fifo_unchanged got level %0d head %h want 4 00", level, out_data);
    end
    clr_ovf  = 1'b0;
    in_valid = 1'b0;
    step();
    n_checks++;
    if (overflow !== 1'b1) begin n_errors++; $display("FAIL clr_hold got %b want 1", overflow); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'(i);
      step();
    end
    n_checks++;
    if (level !== 3'd3) begin n_errors++; $display("FAIL rstmid_pre_level got %0d want 3", level); end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
    n_checks++;
    if (level !== 3'd0) begin n_errors++; $display("FAIL rstmid_level got %0d want 0", level); end
    n_checks++;
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL rstmid_overflow got %b want 0", overflow); end
    n_checks++;
    if (out_data !== 8'h00) begin n_errors++; $display("FAIL rstmid_data got %h want 00", out_data); end
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h55) begin
      n_errors++; $display("FAIL rstmid_first got valid %b data %h want 1 55", out_valid, out_data);
    end
    in_data = 8'h66;
    step();
    n_checks++;
    if (level !== 3'd1 || out_data !== 8'h55) begin
      n_errors++; $display("FAIL rstmid_second got level %0d data %h want 1 55", level, out_data);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_overflow();
    test_full_pop();
    test_ovf_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_decim_buffer.md
Name: fir_decim_buffer

Overview:
- Sits directly downstream of the 4-tap fixed-coefficient FIR and consumes its output sample stream.
- Keeps every DEC-th accepted FIR output sample and stores it in a small FIFO.
- Presents kept samples to the next stage over a valid/ready handshake, so a stalling consumer does not break the free-running FIR.
- Reports FIFO occupancy and a sticky overflow flag.

Parameters:
- D_W, 8, sample width; must match the FIR output width; two's complement.
- DEC, 4, decimation factor, >= 2; phase counter width CW = $clog2(DEC).
- DEPTH, 4, FIFO entries; power of two, >= 2; pointer width AW = $clog2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data holds a FIR output sample this cycle.
- in_data  in  D_W  FIR output sample.
- out_valid  out  1  FIFO non-empty; out_data is valid.
- out_data  out  D_W  FIFO head sample.
- out_ready  in  1  consumer accepts the head this cycle.
- level  out  AW+1  current FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: a kept sample was dropped.
- clr_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-operation):
  - phase counter, read pointer, write pointer, level and overflow go to 0.
  - FIFO contents are don't-care; out_valid=0 and out_data=0 (output mux gated by empty).
  - In-flight samples are discarded.
  - After release, the first accepted sample is kept.
- Phase counter:
  - Advances only on in_valid=1, counting 0..DEC-1 and wrapping DEC-1 -> 0.
  - The sample is kept when the counter = 0 at its in_valid cycle.
  - The counter advances whether or not the kept sample was actually written (drops do not shift the phase).
- Push: keep=1 and (level<DEPTH or pop=1 this cycle).
  - Writes in_data at wr_ptr on that edge; wr_ptr wraps modulo DEPTH.
- Pop: out_valid=1 and out_ready=1.
  - rd_ptr advances on that edge and wraps modulo DEPTH.
  - out_ready while out_valid=0 has no effect.
- level:
  - +1 on push only, -1 on pop only, unchanged on push+pop or neither.
  - Never exceeds DEPTH and never underflows.
- out_valid = (level != 0). out_data = mem[rd_ptr] when non-empty, else 0.
- Latency: a sample kept at edge N appears on out_valid/out_data after edge N (visible in cycle N+1). No combinational path from in_* to out_*.
- Data is passed bit-exact: no rounding, no sign change, no width change.
- Full and simultaneous pop: the push is allowed, level stays DEPTH, no overflow.
- Full with no pop and keep=1: the sample is dropped, overflow is set on that edge, and the FIFO is unchanged.
- Empty with keep=1 and out_ready=1: no pop that cycle (out_valid=0), so the push succeeds and level becomes 1. The FIFO does not fall through.
- overflow:
  - Set takes priority over clr_ovf on the same edge.
  - Otherwise clr_ovf=1 clears it.
  - Stays set until cleared or reset.
- Non-kept samples (counter != 0) never affect the FIFO or overflow.
- All state is updated on the rising edge of clk only, apart from the asynchronous reset.

Test Plan:
- Basic decimation: DEC=4, in_valid=1 continuously, in_data = 1,2,3,...,16, out_ready=1 → outputs 1, 5, 9, 13 in order, each one cycle after its input edge; overflow stays 0; level never exceeds 1.
- Gapped input: in_valid pattern 1,0,0,1,1,0,1,1,1 with data 10,x,x,11,12,x,13,14,15 → kept samples are 10 and 14. Counter advances only on valid cycles.
- Backpressure / overflow:
  - DEPTH=4, DEC=4, out_ready=0, feed 20 consecutive valid samples 0..19 → FIFO holds 0, 4, 8, 12; level=4.
  - Sample 16 is dropped and overflow=1 from the edge where 16 is offered.
  - Then out_ready=1 → drains 0, 4, 8, 12, with level stepping to 0.
- Full with simultaneous pop: level=4, out_ready=1 in the cycle a kept sample (value 0x7F) arrives → level stays 4, overflow stays 0, 0x7F drains last.
- Overflow clear priority: overflow=1 and clr_ovf=1 with no drop → cleared next edge. clr_ovf=1 in the same cycle as a new drop → overflow remains 1.
- Reset mid-stream: assert rst_n=0 asynchronously with level=3 and the counter at 2 → out_valid, level and overflow drop to 0 immediately, without waiting for a clock edge. After release, the first valid sample (0x55) is kept and output next cycle.
